// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial sequence detector family.
// Default pattern is the legacy 1011 sync word; fill counters size via fill_width().
package seq_det_pkg;

    localparam int         DEFAULT_PATTERN_LEN = 4;
    localparam int         DEFAULT_COUNT_WIDTH = 8;
    localparam logic [3:0] DEFAULT_PATTERN     = 4'b1011;

    // Enough bits to hold every fill level 0..len inclusive.
    function automatic int fill_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear plus increment yields 1.
// Latency: count and sat update on the edge that samples inc/clr. No backpressure.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             sat
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             sat_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? WIDTH'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // sat is registered from the next count so it tracks count on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= (count_d == '1);
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/moore_seq_detector.sv
// Programmable Moore serial pattern detector with overlap control and saturating match count.
// Latency: detector_out is high the cycle after the final pattern bit is sampled. No backpressure.
module moore_seq_detector
    import seq_det_pkg::*;
#(
    parameter int                     PATTERN_LEN = DEFAULT_PATTERN_LEN,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = PATTERN_LEN'(DEFAULT_PATTERN),
    parameter int                     COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   sequence_in,
    input  logic                   enable,
    input  logic                   overlap_en,
    input  logic                   pattern_load,
    input  logic [PATTERN_LEN-1:0] pattern_in,
    input  logic                   clear_count,
    output logic                   detector_out,
    output logic [COUNT_WIDTH-1:0] match_count,
    output logic                   count_sat
);

    localparam int             FW        = fill_width(PATTERN_LEN);
    localparam logic [FW-1:0]  FILL_ARM  = FW'(PATTERN_LEN - 1);
    localparam logic [FW-1:0]  FILL_FULL = FW'(PATTERN_LEN);

    logic [PATTERN_LEN-1:0] pat_q;
    logic [PATTERN_LEN-1:0] pat_d;
    logic [PATTERN_LEN-1:0] hist_q;
    logic [PATTERN_LEN-1:0] hist_d;
    logic [PATTERN_LEN-1:0] cand;
    logic [FW-1:0]          fill_q;
    logic [FW-1:0]          fill_d;
    logic                   det_q;
    logic                   det_d;
    logic                   hit;
    logic                   count_inc;

    // A hit needs PATTERN_LEN valid bits: the current one plus at least LEN-1 in history.
    assign cand      = {hist_q[PATTERN_LEN-2:0], sequence_in};
    assign hit       = enable && (fill_q >= FILL_ARM) && (cand == pat_q);
    assign count_inc = hit && !pattern_load;

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        det_d  = 1'b0;
        if (pattern_load) begin
            pat_d  = pattern_in;
            hist_d = '0;
            fill_d = '0;
        end else if (enable) begin
            det_d = hit;
            if (hit && !overlap_en) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = cand;
                fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            det_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            det_q  <= det_d;
        end
    end

    assign detector_out = det_q;

    sat_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_match_count (
        .clock (clock),
        .reset (reset),
        .inc   (count_inc),
        .clr   (clear_count),
        .count (match_count),
        .sat   (count_sat)
    );

endmodule

// File: doc/moore_seq_detector.md
# moore_seq_detector

Parametrised, runtime-programmable Moore serial sequence detector: the next generation of the fixed 4-bit pattern detectors in the sequential-circuits library. It samples one serial bit per enabled clock and compares the last PATTERN_LEN bits against a loadable pattern register. A registered one-cycle match flag and a saturating match counter are produced, with selectable overlapping or non-overlapping detection. It sits behind any serial front end (deserialiser, UART bit stream, LFSR checker) as the framing/sync-word detector.

## Interface
- PATTERN_LEN, 4: pattern length in bits; legal range 2..32.
- PATTERN, 4'b1011: reset value of the pattern register; MSB is the first bit in time.
- COUNT_WIDTH, 8: width of match_count; legal range 1..32.
- clock  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, asynchronous, active-high; clears all state.
- sequence_in  input  1  serial data bit, sampled when enable=1.
- enable  input  1  sample qualifier; when 0, history and fill do not advance.
- overlap_en  input  1  1 = overlapping detection; 0 = non-overlapping.
- pattern_load  input  1  loads pattern_in into the pattern register.
- pattern_in  input  PATTERN_LEN  new pattern, MSB first in time.
- clear_count  input  1  synchronous clear of match_count.
- detector_out  output  1  Moore match flag; high for the cycle after the matching bit is sampled.
- match_count  output  COUNT_WIDTH  saturating number of matches since reset/clear.
- count_sat  output  1  high while match_count is all ones.

## Operation
- Internal state: pattern register pat, history register hist[PATTERN_LEN-1:0], fill counter fill (0..PATTERN_LEN, width $clog2(PATTERN_LEN+1)).
- Reset values: pat=PATTERN, hist=0, fill=0, detector_out=0, match_count=0, count_sat=0.
- Candidate word: cand = {hist[PATTERN_LEN-2:0], sequence_in}. Match = enable & (fill >= PATTERN_LEN-1) & (cand == pat).
- Edge priority, highest first:
  - pattern_load=1: pat <= pattern_in; hist <= 0; fill <= 0; detector_out <= 0. The sequence_in bit is discarded. The counter is unaffected except by clear_count.
  - enable=1: hist <= cand; fill <= min(fill+1, PATTERN_LEN); detector_out <= match.
    - On a match with overlap_en=0, fill <= 0 and hist <= 0, so the next match needs PATTERN_LEN fresh bits.
    - On a match with overlap_en=1, hist and fill advance normally.
  - enable=0: hist and fill hold; detector_out <= 0.
- Counter:
  - A match increments match_count, which saturates at 2^COUNT_WIDTH-1.
  - clear_count alone sets match_count to 0.
  - clear_count together with a match sets match_count to 1.
  - count_sat is registered and equals (match_count == all ones).
- Overlap mode with the default parameters reproduces the legacy fixed 1011 Moore detector behaviour exactly.
- overlap_en may change on any cycle; it takes effect on the next match evaluation.

## Timing
- Latency: detector_out rises in the cycle immediately after the clock edge that samples the final pattern bit. It lasts one cycle unless the next sampled bit completes another overlapping match (e.g. pattern 1111 with input of all ones gives a continuous high).
- match_count and count_sat update on the same edge as detector_out.
- The first possible match after reset, load, or a non-overlap match is on the PATTERN_LEN-th enabled sample.
- Reset mid-stream clears everything asynchronously. No partial match survives, and detector_out drops immediately.
- enable gaps are transparent: bits are matched across gaps, but detector_out is 0 on every non-sampling cycle.

## Structure
- Shared package seq_det_pkg holds the default pattern constant (4'b1011), the default PATTERN_LEN and COUNT_WIDTH, and a function for the fill width ($clog2(len+1)).
- One sub-module: sat_counter (parameter WIDTH; inputs inc, clr; outputs count, sat), instantiated for match_count. It is reusable by the other detectors in the library.
- The top level holds the pat/hist/fill registers and the match compare.

## Test plan
- Defaults, overlap_en=1, enable=1, stream 1,0,1,1,0,1,1 -> detector_out high after the 4th and 7th bits; match_count=2.
- Same stream with overlap_en=0 -> only one pulse, after the 4th bit; match_count=1.
- pattern_load with pattern_in=4'b1111, then eight 1s with overlap_en=1 -> detector_out high from after the 4th bit through the 8th (5 cycles); match_count=5. With overlap_en=0 -> pulses after the 4th and 8th bits only.
- Stream 1,0,1,1 with enable=0 cycles between every bit -> one pulse after the last sampled 1; detector_out=0 on all gap cycles.
- COUNT_WIDTH=2, five overlapping matches -> count stops at 3 with count_sat=1. clear_count alone -> 0. clear_count together with a match -> 1.
- Assert reset after 1,0,1 and then send 1 -> no pulse; all outputs are 0 during and after the reset.
